// File: rtl/kbd_pkg.sv
// Shared constants, scan codes and FSM state encoding for the keyboard-to-video-memory writer.
package kbd_pkg;

  localparam int COLS = 70;
  localparam int ROWS = 30;

  localparam logic [7:0] SC_BRK    = 8'hF0;
  localparam logic [7:0] SC_EXT    = 8'hE0;
  localparam logic [7:0] SC_LSHIFT = 8'h12;
  localparam logic [7:0] SC_RSHIFT = 8'h59;
  localparam logic [7:0] SC_ENTER  = 8'h5A;
  localparam logic [7:0] SC_BKSP   = 8'h66;
  localparam logic [7:0] SC_ESC    = 8'h76;
  localparam logic [7:0] SC_SPACE  = 8'h29;

  localparam logic [7:0] ASCII_SPACE = 8'h20;

  typedef enum logic [2:0] {
    CLRALL,
    IDLE,
    BRK,
    EXT,
    WR,
    CLRROW
  } state_e;

endpackage

// File: rtl/kbd_scan2ascii.sv
// PS/2 set-2 make code to ASCII lookup; shift selects uppercase or shifted symbol, 0x00 if unmapped.
module kbd_scan2ascii
  import kbd_pkg::*;
(
  input  logic [7:0] code,
  input  logic       shift,
  output logic [7:0] ascii
);

  logic [7:0] lo;
  logic [7:0] hi;

  always_comb begin
    lo = 8'h00;
    hi = 8'h00;
    case (code)
      8'h1C: {lo, hi} = "aA";
      8'h32: {lo, hi} = "bB";
      8'h21: {lo, hi} = "cC";
      8'h23: {lo, hi} = "dD";
      8'h24: {lo, hi} = "eE";
      8'h2B: {lo, hi} = "fF";
      8'h34: {lo, hi} = "gG";
      8'h33: {lo, hi} = "hH";
      8'h43: {lo, hi} = "iI";
      8'h3B: {lo, hi} = "jJ";
      8'h42: {lo, hi} = "kK";
      8'h4B: {lo, hi} = "lL";
      8'h3A: {lo, hi} = "mM";
      8'h31: {lo, hi} = "nN";
      8'h44: {lo, hi} = "oO";
      8'h4D: {lo, hi} = "pP";
      8'h15: {lo, hi} = "qQ";
      8'h2D: {lo, hi} = "rR";
      8'h1B: {lo, hi} = "sS";
      8'h2C: {lo, hi} = "tT";
      8'h3C: {lo, hi} = "uU";
      8'h2A: {lo, hi} = "vV";
      8'h1D: {lo, hi} = "wW";
      8'h22: {lo, hi} = "xX";
      8'h35: {lo, hi} = "yY";
      8'h1A: {lo, hi} = "zZ";
      8'h16: {lo, hi} = "1!";
      8'h1E: {lo, hi} = "2@";
      8'h26: {lo, hi} = "3#";
      8'h25: {lo, hi} = "4$";
      8'h2E: {lo, hi} = "5%";
      8'h36: {lo, hi} = "6^";
      8'h3D: {lo, hi} = "7&";
      8'h3E: {lo, hi} = "8*";
      8'h46: {lo, hi} = "9(";
      8'h45: {lo, hi} = "0)";
      SC_SPACE: {lo, hi} = "  ";
      8'h0E: {lo, hi} = "`~";
      8'h4E: {lo, hi} = "-_";
      8'h55: {lo, hi} = "=+";
      8'h54: {lo, hi} = "[{";
      8'h5B: {lo, hi} = "]}";
      8'h5D: {lo, hi} = 16'h5C7C;
      8'h4C: {lo, hi} = ";:";
      8'h52: {lo, hi} = 16'h2722;
      8'h41: {lo, hi} = ",<";
      8'h49: {lo, hi} = ".>";
      8'h4A: {lo, hi} = "/?";
      default: {lo, hi} = 16'h0000;
    endcase
    ascii = shift ? hi : lo;
  end

endmodule

// File: rtl/kbd_vmem_writer.sv
// Turns PS/2 set-2 scan codes into text-memory writes with a cursor, line wrap and screen/row clearing.
module kbd_vmem_writer #(
  parameter int COLS = kbd_pkg::COLS,
  parameter int ROWS = kbd_pkg::ROWS
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        sc_valid,
  input  logic [7:0]  sc_data,
  output logic        sc_ready,
  output logic        vmem_we,
  output logic [11:0] vmem_addr,
  output logic [7:0]  vmem_wdata,
  output logic [6:0]  cur_col,
  output logic [4:0]  cur_row
);
  import kbd_pkg::*;

  localparam logic [6:0] COL_LAST = 7'(COLS - 1);
  localparam logic [6:0] COL_END  = 7'(COLS);
  localparam logic [4:0] ROW_LAST = 5'(ROWS - 1);

  state_e      state_q, state_d;
  logic [6:0]  clr_col_q, clr_col_d;
  logic [4:0]  clr_row_q, clr_row_d;
  logic [6:0]  col_q, col_d;
  logic [4:0]  row_q, row_d;
  logic        shift_q, shift_d;
  logic        nl_q, nl_d;
  logic        we_q, we_d;
  logic [11:0] addr_q, addr_d;
  logic [7:0]  wdata_q, wdata_d;

  logic [7:0]  ascii;
  logic [6:0]  wr_col;
  logic [4:0]  wr_row;
  logic [7:0]  wr_data;
  logic [4:0]  row_nxt;
  logic        xfer;

  kbd_scan2ascii u_scan2ascii (
    .code  (sc_data),
    .shift (shift_q),
    .ascii (ascii)
  );

  assign xfer    = sc_valid & sc_ready;
  assign row_nxt = (row_q == ROW_LAST) ? 5'd0 : row_q + 5'd1;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= CLRALL;
      clr_col_q <= '0;
      clr_row_q <= '0;
      col_q     <= '0;
      row_q     <= '0;
      shift_q   <= 1'b0;
      nl_q      <= 1'b0;
      we_q      <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
    end else begin
      state_q   <= state_d;
      clr_col_q <= clr_col_d;
      clr_row_q <= clr_row_d;
      col_q     <= col_d;
      row_q     <= row_d;
      shift_q   <= shift_d;
      nl_q      <= nl_d;
      we_q      <= we_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
    end
  end

  // Clear counters sit at COL_END for one final cycle so the last clear write is visible before sc_ready.
  always_comb begin
    state_d   = state_q;
    clr_col_d = clr_col_q;
    clr_row_d = clr_row_q;
    col_d     = col_q;
    row_d     = row_q;
    shift_d   = shift_q;
    nl_d      = nl_q;
    wr_col    = col_q;
    wr_row    = row_q;
    wr_data   = ascii;
    unique case (state_q)
      CLRALL: begin
        if (clr_col_q == COL_END) begin
          state_d   = IDLE;
          clr_col_d = '0;
          clr_row_d = '0;
          col_d     = '0;
          row_d     = '0;
          shift_d   = 1'b0;
        end else if (clr_row_q == ROW_LAST) begin
          clr_row_d = '0;
          clr_col_d = clr_col_q + 7'd1;
        end else begin
          clr_row_d = clr_row_q + 5'd1;
        end
      end
      CLRROW: begin
        if (clr_col_q == COL_END) begin
          state_d   = IDLE;
          clr_col_d = '0;
        end else begin
          clr_col_d = clr_col_q + 7'd1;
        end
      end
      WR: begin
        state_d = nl_q ? CLRROW : IDLE;
        nl_d    = 1'b0;
      end
      BRK: begin
        if (xfer) begin
          state_d = IDLE;
          if (sc_data == SC_LSHIFT || sc_data == SC_RSHIFT) shift_d = 1'b0;
        end
      end
      EXT: begin
        if (xfer) state_d = (sc_data == SC_BRK) ? BRK : IDLE;
      end
      IDLE: begin
        if (xfer) begin
          case (sc_data)
            SC_BRK:               state_d = BRK;
            SC_EXT:               state_d = EXT;
            SC_LSHIFT, SC_RSHIFT: shift_d = 1'b1;
            SC_ESC:               state_d = CLRALL;
            SC_ENTER: begin
              col_d   = '0;
              row_d   = row_nxt;
              state_d = CLRROW;
            end
            SC_BKSP: begin
              if (col_q != 7'd0) begin
                wr_col  = col_q - 7'd1;
                col_d   = col_q - 7'd1;
                wr_data = ASCII_SPACE;
                state_d = WR;
              end else if (row_q != 5'd0) begin
                wr_col  = COL_LAST;
                wr_row  = row_q - 5'd1;
                col_d   = COL_LAST;
                row_d   = row_q - 5'd1;
                wr_data = ASCII_SPACE;
                state_d = WR;
              end
            end
            default: begin
              if (ascii != 8'h00) begin
                state_d = WR;
                if (col_q == COL_LAST) begin
                  col_d = '0;
                  row_d = row_nxt;
                  nl_d  = 1'b1;
                end else begin
                  col_d = col_q + 7'd1;
                end
              end
            end
          endcase
        end
      end
      default: state_d = CLRALL;
    endcase
  end

  always_comb begin
    sc_ready = (state_q == IDLE) || (state_q == BRK) || (state_q == EXT);
    we_d     = 1'b0;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    if (state_d == WR) begin
      we_d    = 1'b1;
      addr_d  = {wr_col, wr_row};
      wdata_d = wr_data;
    end else if (state_q == CLRROW && clr_col_q != COL_END) begin
      we_d    = 1'b1;
      addr_d  = {clr_col_q, row_q};
      wdata_d = ASCII_SPACE;
    end else if (state_q == CLRALL && clr_col_q != COL_END) begin
      we_d    = 1'b1;
      addr_d  = {clr_col_q, clr_row_q};
      wdata_d = ASCII_SPACE;
    end
  end

  assign vmem_we    = we_q;
  assign vmem_addr  = addr_q;
  assign vmem_wdata = wdata_q;
  assign cur_col    = col_q;
  assign cur_row    = row_q;

endmodule

// File: tb/tb_kbd_vmem_writer.sv
// Bench for kbd_vmem_writer: directed scenarios plus random scan streams against a cursor/screen model.
module tb_kbd_vmem_writer;
  localparam int COLS = 70;
  localparam int ROWS = 30;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        sc_valid = 1'b0;
  logic [7:0]  sc_data = 8'h00;
  logic        sc_ready;
  logic        vmem_we;
  logic [11:0] vmem_addr;
  logic [7:0]  vmem_wdata;
  logic [6:0]  cur_col;
  logic [4:0]  cur_row;

  kbd_vmem_writer #(.COLS(COLS), .ROWS(ROWS)) dut (
    .clk        (clk),
    .rst        (rst),
    .sc_valid   (sc_valid),
    .sc_data    (sc_data),
    .sc_ready   (sc_ready),
    .vmem_we    (vmem_we),
    .vmem_addr  (vmem_addr),
    .vmem_wdata (vmem_wdata),
    .cur_col    (cur_col),
    .cur_row    (cur_row)
  );

  always #5 clk = ~clk;

  int compared = 0;
  int mismatched = 0;

  // Observed and expected writes, each packed as {col[6:0], row[4:0], data[7:0]}.
  logic [19:0] wq[$];
  logic [19:0] exp_q[$];

  always @(negedge clk) if (vmem_we === 1'b1) wq.push_back({vmem_addr, vmem_wdata});

  logic [7:0] kcode [48] = '{
    8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B, 8'h34, 8'h33, 8'h43, 8'h3B, 8'h42, 8'h4B, 8'h3A,
    8'h31, 8'h44, 8'h4D, 8'h15, 8'h2D, 8'h1B, 8'h2C, 8'h3C, 8'h2A, 8'h1D, 8'h22, 8'h35, 8'h1A,
    8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36, 8'h3D, 8'h3E, 8'h46, 8'h45,
    8'h29, 8'h0E, 8'h4E, 8'h55, 8'h54, 8'h5B, 8'h5D, 8'h4C, 8'h52, 8'h41, 8'h49, 8'h4A};
  logic [7:0] klo [48] = '{
    8'h61, 8'h62, 8'h63, 8'h64, 8'h65, 8'h66, 8'h67, 8'h68, 8'h69, 8'h6A, 8'h6B, 8'h6C, 8'h6D,
    8'h6E, 8'h6F, 8'h70, 8'h71, 8'h72, 8'h73, 8'h74, 8'h75, 8'h76, 8'h77, 8'h78, 8'h79, 8'h7A,
    8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39, 8'h30,
    8'h20, 8'h60, 8'h2D, 8'h3D, 8'h5B, 8'h5D, 8'h5C, 8'h3B, 8'h27, 8'h2C, 8'h2E, 8'h2F};
  logic [7:0] khi [48] = '{
    8'h41, 8'h42, 8'h43, 8'h44, 8'h45, 8'h46, 8'h47, 8'h48, 8'h49, 8'h4A, 8'h4B, 8'h4C, 8'h4D,
    8'h4E, 8'h4F, 8'h50, 8'h51, 8'h52, 8'h53, 8'h54, 8'h55, 8'h56, 8'h57, 8'h58, 8'h59, 8'h5A,
    8'h21, 8'h40, 8'h23, 8'h24, 8'h25, 8'h5E, 8'h26, 8'h2A, 8'h28, 8'h29,
    8'h20, 8'h7E, 8'h5F, 8'h2B, 8'h7B, 8'h7D, 8'h7C, 8'h3A, 8'h22, 8'h3C, 8'h3E, 8'h3F};

  int mcol, mrow, mmode;
  bit mshift;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] lookup(input logic [7:0] c, input bit sh);
    for (int i = 0; i < 48; i++)
      if (kcode[i] == c) return sh ? khi[i] : klo[i];
    return 8'h00;
  endfunction

  task automatic mdl_write(input int c, input int r, input logic [7:0] d);
    exp_q.push_back({7'(c), 5'(r), d});
  endtask

  task automatic mdl_clear_row(input int r);
    for (int c = 0; c < COLS; c++) mdl_write(c, r, 8'h20);
  endtask

  task automatic mdl_clear_all();
    for (int c = 0; c < COLS; c++)
      for (int r = 0; r < ROWS; r++) mdl_write(c, r, 8'h20);
    mcol = 0; mrow = 0; mshift = 0; mmode = 0;
  endtask

  task automatic mdl_key(input logic [7:0] b);
    int p;
    logic [7:0] a;
    p = mrow * COLS + mcol;
    if (mmode == 1) begin
      if (b == 8'h12 || b == 8'h59) mshift = 0;
      mmode = 0;
    end else if (mmode == 2) begin
      mmode = (b == 8'hF0) ? 1 : 0;
    end else if (b == 8'hF0) mmode = 1;
    else if (b == 8'hE0) mmode = 2;
    else if (b == 8'h12 || b == 8'h59) mshift = 1;
    else if (b == 8'h76) mdl_clear_all();
    else if (b == 8'h5A) begin
      mcol = 0;
      mrow = (mrow + 1) % ROWS;
      mdl_clear_row(mrow);
    end else if (b == 8'h66) begin
      if (p > 0) begin
        p--;
        mcol = p % COLS; mrow = p / COLS;
        mdl_write(mcol, mrow, 8'h20);
      end
    end else begin
      a = lookup(b, mshift);
      if (a != 8'h00) begin
        mdl_write(mcol, mrow, a);
        p = (p + 1) % (COLS * ROWS);
        mcol = p % COLS; mrow = p / COLS;
        if (mcol == 0) mdl_clear_row(mrow);
      end
    end
  endtask

  task automatic wait_ready(input string tag);
    int n;
    n = 0;
    while (sc_ready !== 1'b1 && n < 3000) begin
      @(negedge clk); #1;
      n++;
    end
    chk({tag, "_ready"}, 32'(sc_ready), 32'd1);
  endtask

  task automatic send_byte(input logic [7:0] b);
    wait_ready("pre_send");
    sc_valid = 1'b1;
    sc_data  = b;
    @(posedge clk); #1;
    sc_valid = 1'b0;
    sc_data  = 8'(~b);
  endtask

  task automatic settle(input string tag);
    wait_ready(tag);
    chk({tag, "_nwr"}, 32'(wq.size()), 32'(exp_q.size()));
    for (int i = 0; i < wq.size() && i < exp_q.size(); i++)
      chk({tag, "_wr"}, 32'(wq[i]), 32'(exp_q[i]));
    wq.delete();
    exp_q.delete();
    chk({tag, "_col"}, 32'(cur_col), 32'(mcol));
    chk({tag, "_row"}, 32'(cur_row), 32'(mrow));
  endtask

  task automatic press(input logic [7:0] b, input string tag);
    send_byte(b);
    mdl_key(b);
    settle(tag);
  endtask

  task automatic check_reset(input string tag);
    chk({tag, "_we"},    32'(vmem_we),    32'd0);
    chk({tag, "_addr"},  32'(vmem_addr),  32'd0);
    chk({tag, "_wdata"}, 32'(vmem_wdata), 32'd0);
    chk({tag, "_col"},   32'(cur_col),    32'd0);
    chk({tag, "_row"},   32'(cur_row),    32'd0);
    chk({tag, "_rdy"},   32'(sc_ready),   32'd0);
  endtask

  initial begin
    logic [7:0] b;
    int sel;
    repeat (3) @(negedge clk);
    #1;
    check_reset("rst");
    rst = 1'b1;
    mdl_clear_all();
    settle("init");

    // Plain, shifted and released-shift letter with write latency checks.
    send_byte(8'h1C);
    mdl_key(8'h1C);
    chk("lat_we",   32'(vmem_we),    32'd1);
    chk("lat_addr", 32'(vmem_addr),  32'h000);
    chk("lat_data", 32'(vmem_wdata), 32'h61);
    chk("lat_col",  32'(cur_col),    32'd1);
    @(posedge clk); #1;
    chk("lat_rdy",  32'(sc_ready),   32'd1);
    settle("a_lo");
    press(8'h12, "shift_on");
    send_byte(8'h1C);
    mdl_key(8'h1C);
    chk("a_hi_data", 32'(vmem_wdata), 32'h41);
    settle("a_hi");
    press(8'hF0, "brk");
    press(8'h12, "shift_off");
    send_byte(8'h1C);
    mdl_key(8'h1C);
    chk("a_lo2_data", 32'(vmem_wdata), 32'h61);
    settle("a_lo2");

    // Last cell of the screen wraps to (0,0) and clears row 0.
    press(8'h76, "esc");
    for (int i = 0; i < ROWS - 1; i++) press(8'h5A, "enter");
    for (int i = 0; i < COLS - 1; i++) press(kcode[$urandom_range(0, 47)], "fill");
    chk("corner_col", 32'(cur_col), 32'd69);
    chk("corner_row", 32'(cur_row), 32'd29);
    press(8'h1C, "wrap");
    chk("wrap_col", 32'(cur_col), 32'd0);
    chk("wrap_row", 32'(cur_row), 32'd0);

    // Backspace across a line boundary, and at the home position.
    press(8'h76, "esc2");
    for (int i = 0; i < 5; i++) press(8'h5A, "enter5");
    press(8'h66, "bksp_line");
    chk("bksp_col", 32'(cur_col), 32'd69);
    chk("bksp_row", 32'(cur_row), 32'd4);
    press(8'h76, "esc3");
    press(8'h66, "bksp_home");

    // Extended make/break codes and a stray break must not write.
    press(8'h1C, "pre_ext");
    press(8'hE0, "ext1");
    press(8'h75, "ext2");
    press(8'hE0, "ext3");
    press(8'hF0, "ext4");
    press(8'h75, "ext5");
    press(8'hF0, "ext6");
    press(8'h1C, "ext7");
    chk("ext_col", 32'(cur_col), 32'd1);

    for (int i = 0; i < 300; i++) begin
      sel = $urandom_range(0, 99);
      if (sel < 55)      b = kcode[$urandom_range(0, 47)];
      else if (sel < 63) b = 8'hF0;
      else if (sel < 67) b = 8'hE0;
      else if (sel < 72) b = ($urandom_range(0, 1) != 0) ? 8'h12 : 8'h59;
      else if (sel < 78) b = 8'h5A;
      else if (sel < 90) b = 8'h66;
      else if (sel < 99) b = 8'($urandom_range(0, 255));
      else               b = 8'h76;
      press(b, "rand");
    end

    // Reset in the middle of a full clear restarts it from address 0.
    send_byte(8'h76);
    begin
      int n;
      n = 0;
      while (wq.size() < 500 && n < 3000) begin
        @(negedge clk); #1;
        n++;
      end
    end
    chk("mid_cnt", 32'(wq.size()), 32'd500);
    rst = 1'b0;
    #1;
    check_reset("midrst");
    repeat (3) @(negedge clk);
    #1;
    check_reset("midrst_hold");
    rst = 1'b1;
    wq.delete();
    exp_q.delete();
    mdl_clear_all();
    settle("reclear");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/kbd_vmem_writer.md
KBD_VMEM_WRITER -- requirements
Module: kbd_vmem_writer

Interface
REQ-001 Parameter COLS, default 70, text columns per screen.
REQ-002 Parameter ROWS, default 30, text rows per screen.
REQ-003 clk  input  1  single clock; all state changes on the rising edge.
REQ-004 rst  input  1  asynchronous, active-low reset (asserted at 0).
REQ-005 sc_valid  input  1  PS/2 set-2 scan code byte available.
REQ-006 sc_data  input  8  scan code byte.
REQ-007 sc_ready  output  1  block accepts sc_data this cycle; transfer = sc_valid & sc_ready.
REQ-008 vmem_we  output  1  one-cycle write strobe to text memory.
REQ-009 vmem_addr  output  12  column-priority address {col[6:0], row[4:0]}.
REQ-010 vmem_wdata  output  8  ASCII byte to write.
REQ-011 cur_col  output  7  cursor column, 0..COLS-1.
REQ-012 cur_row  output  5  cursor row, 0..ROWS-1.

Function
REQ-013 States SHALL be CLRALL, IDLE, BRK, EXT, WR, CLRROW; sc_ready = 1 only in IDLE, BRK and EXT.
REQ-014 IDLE: transfer of 0xF0 -> BRK; 0xE0 -> EXT; a make code -> per REQ-016..REQ-020.
REQ-015 BRK: next transfer releases a key; 0x12 or 0x59 clears shift; any other byte is discarded; -> IDLE; no write.
REQ-016 EXT: transfer of 0xF0 -> BRK; any other byte is discarded -> IDLE; no write.
REQ-017 Make 0x12 or 0x59 sets shift, with no write.
REQ-018 Printable make code (letters, digits, space 0x29, punctuation as tabulated in kbd_scan2ascii) -> WR.
- Write data: ASCII from the table; shift selects uppercase or the shifted symbol.
- Writes at the current cursor.
- Cursor advances: col+1; col COLS-1 -> col 0 with row+1.
REQ-019 Enter 0x5A -> col 0, row+1, then CLRROW on the new row.
REQ-020 Backspace 0x66 -> WR writing 0x20 at the previous position.
- col>0: previous position is (col-1, row).
- col 0, row>0: previous position is (COLS-1, row-1).
- At (0,0): no write and no cursor change.
- Cursor ends on the cleared cell.
REQ-021 Esc 0x76 -> CLRALL.
REQ-022 Make codes that are unmapped, and ASCII 0x00 table entries, SHALL be accepted and discarded with no write.
REQ-023 Row increment past ROWS-1 SHALL wrap to row 0; any row entered by wrap or line advance SHALL be cleared through CLRROW.
REQ-024 Latency: a transfer in cycle N SHALL assert vmem_we for exactly cycle N+1, with vmem_addr/vmem_wdata registered; the cursor update is visible in cycle N+1; sc_ready is 1 again in cycle N+2 unless CLRROW/CLRALL follows.
REQ-025 CLRROW SHALL write 0x20 to columns 0..COLS-1 of cur_row, one per cycle; it takes COLS consecutive vmem_we cycles, then -> IDLE.
REQ-026 CLRALL SHALL write 0x20 to every (col,row) in column-major order, col outer, row inner; it takes COLS*ROWS cycles, then cursor (0,0), shift 0, -> IDLE.
REQ-027 Addresses with row>=ROWS or col>=COLS SHALL never be written.
REQ-028 The shift flag SHALL persist across writes and SHALL be updated only by REQ-015/REQ-017.

Reset
REQ-029 While rst=0, the block SHALL hold the following.
- State: CLRALL, clear counter 0.
- Outputs: vmem_we 0, vmem_addr 0, vmem_wdata 0x00, cur_col 0, cur_row 0, sc_ready 0.
- Shift flag: 0.
REQ-030 After rst releases, the block SHALL perform the full CLRALL sequence before first asserting sc_ready.
REQ-031 Reset asserted mid-clear or mid-write SHALL abort immediately; the clear SHALL restart from address 0 after release.

Structure
REQ-032 Package kbd_pkg SHALL hold the following.
- Constants: COLS, ROWS.
- Scan code constants: F0, E0, 12, 59, 5A, 66, 76, 29.
- ASCII_SPACE.
- The state enum.
REQ-033 Combinational sub-module kbd_scan2ascii SHALL map (scan code, shift) to ASCII, returning 0x00 for unmapped codes.

Verification
REQ-034 Release reset -> exactly 2100 vmem_we pulses with data 0x20, each address written once, then sc_ready=1 and cursor (0,0).
REQ-035 Send 0x1C -> one write addr {7'd0,5'd0}, data 0x61, cursor (1,0); send 0x12, 0x1C -> data 0x41; send 0xF0,0x12,0x1C -> data 0x61.
REQ-036 With cursor (69,29), send 0x1C -> write at {7'd69,5'd29}, then cursor (0,0), then 70 writes of 0x20 to row 0.
REQ-037 With cursor (0,5), send 0x66 -> write 0x20 at {7'd69,5'd4}, cursor (69,4); at (0,0), send 0x66 -> no write.
REQ-038 Send 0xE0,0x75,0xE0,0xF0,0x75,0xF0,0x1C -> no writes, cursor unchanged.
REQ-039 Assert rst during CLRALL at cell 500 -> outputs return to reset values; after release, the clear restarts at address 0 and completes 2100 writes.
